// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the CDB,
// and issues the oldest fully-ready entry through a registered valid/ready port.
module alu_reservation_station #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [3:0]                     disp_alu_ctrl,
  input  logic [TAG_W-1:0]               disp_dest_tag,
  input  logic                           disp_src1_rdy,
  input  logic                           disp_src2_rdy,
  input  logic [TAG_W-1:0]               disp_src1_tag,
  input  logic [TAG_W-1:0]               disp_src2_tag,
  input  logic [DATA_W-1:0]              disp_src1_val,
  input  logic [DATA_W-1:0]              disp_src2_val,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_value,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [3:0]                     issue_alu_ctrl,
  output logic [DATA_W-1:0]              issue_a,
  output logic [DATA_W-1:0]              issue_b,
  output logic [TAG_W-1:0]               issue_dest_tag,
  output logic [$clog2(ENTRIES+1)-1:0]   count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [TAG_W-1:0]  dest;
    logic              r1, r2;
    logic [TAG_W-1:0]  t1, t2;
    logic [DATA_W-1:0] v1, v2;
  } ent_t;

  logic [ENTRIES-1:0]              vld, rdy, sel_oh;
  logic [ENTRIES-1:0][ENTRIES-1:0] older;  // older[i][j]: entry i dispatched before j
  ent_t                            ent [ENTRIES];
  ent_t                            sel_ent, new_ent;
  logic [IDX_W-1:0]                free_idx;
  logic                            any_rdy, dispatch, load, blk;

  assign disp_ready = count < CNT_W'(ENTRIES);
  assign dispatch   = disp_valid && disp_ready && !flush;
  assign any_rdy    = |rdy;
  assign load       = (!issue_valid || issue_ready) && any_rdy && !flush;

  always_comb begin
    rdy      = '0;
    sel_oh   = '0;
    sel_ent  = '0;
    free_idx = '0;
    blk      = 1'b0;
    for (int i = 0; i < ENTRIES; i++) rdy[i] = vld[i] && ent[i].r1 && ent[i].r2;
    for (int i = 0; i < ENTRIES; i++) begin
      blk = 1'b0;
      for (int j = 0; j < ENTRIES; j++) if (rdy[j] && older[j][i]) blk = 1'b1;
      sel_oh[i] = rdy[i] && !blk;
      if (sel_oh[i]) sel_ent = ent[i];
    end
    for (int i = ENTRIES-1; i >= 0; i--) if (!vld[i]) free_idx = IDX_W'(i);
  end

  // Same-cycle CDB bypass so a just-broadcast producer is not missed.
  always_comb begin
    new_ent      = '0;
    new_ent.ctrl = disp_alu_ctrl;
    new_ent.dest = disp_dest_tag;
    new_ent.t1   = disp_src1_tag;
    new_ent.t2   = disp_src2_tag;
    new_ent.r1   = disp_src1_rdy;
    new_ent.r2   = disp_src2_rdy;
    new_ent.v1   = disp_src1_val;
    new_ent.v2   = disp_src2_val;
    if (!disp_src1_rdy && cdb_valid && disp_src1_tag == cdb_tag) begin
      new_ent.r1 = 1'b1;
      new_ent.v1 = cdb_value;
    end
    if (!disp_src2_rdy && cdb_valid && disp_src2_tag == cdb_tag) begin
      new_ent.r2 = 1'b1;
      new_ent.v2 = cdb_value;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (vld[i] && cdb_valid && !ent[i].r1 && ent[i].t1 == cdb_tag) begin
        ent[i].r1 <= 1'b1;
        ent[i].v1 <= cdb_value;
      end
      if (vld[i] && cdb_valid && !ent[i].r2 && ent[i].t2 == cdb_tag) begin
        ent[i].r2 <= 1'b1;
        ent[i].v2 <= cdb_value;
      end
    end
    if (dispatch) ent[free_idx] <= new_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld            <= '0;
      older          <= '0;
      count          <= '0;
      issue_valid    <= 1'b0;
      issue_alu_ctrl <= '0;
      issue_a        <= '0;
      issue_b        <= '0;
      issue_dest_tag <= '0;
    end else if (flush) begin
      vld         <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      if (load) begin
        vld            <= vld & ~sel_oh;
        issue_valid    <= 1'b1;
        issue_alu_ctrl <= sel_ent.ctrl;
        issue_a        <= sel_ent.v1;
        issue_b        <= sel_ent.v2;
        issue_dest_tag <= sel_ent.dest;
      end else if (issue_ready) begin
        issue_valid <= 1'b0;
      end
      if (dispatch) begin
        vld[free_idx] <= 1'b1;
        for (int j = 0; j < ENTRIES; j++) older[j][free_idx] <= vld[j];
        older[free_idx] <= '0;
      end
      case ({dispatch, load})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        disp_valid = 1'b0, disp_ready;
  logic [3:0]  disp_alu_ctrl = '0;
  logic [5:0]  disp_dest_tag = '0, disp_src1_tag = '0, disp_src2_tag = '0;
  logic        disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
  logic [31:0] disp_src1_val = '0, disp_src2_val = '0;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        issue_valid, issue_ready = 1'b1;
  logic [3:0]  issue_alu_ctrl;
  logic [31:0] issue_a, issue_b;
  logic [5:0]  issue_dest_tag;
  logic [2:0]  count;
  int          n_chk = 0, n_fail = 0;

  alu_reservation_station #(.ENTRIES(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_ctrl(disp_alu_ctrl),
    .disp_dest_tag(disp_dest_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_alu_ctrl(issue_alu_ctrl),
    .issue_a(issue_a), .issue_b(issue_b), .issue_dest_tag(issue_dest_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] ctrl, input logic [5:0] dest,
                      input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] v2);
    disp_valid    = 1'b1;
    disp_alu_ctrl = ctrl;
    disp_dest_tag = dest;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
  endtask

  initial begin
    #1;
    check("rst_issue_valid", 32'(issue_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_disp_ready", 32'(disp_ready), 1);
    check("rst_issue_a", issue_a, 0);
    check("rst_issue_ctrl", 32'(issue_alu_ctrl), 0);
    tick(); rst = 1'b0;

    // basic issue
    disp(4'b0010, 6'd3, 1, 0, 32'd5, 1, 0, 32'd7);
    tick(); disp_valid = 1'b0;
    check("basic_count_after_disp", 32'(count), 1);
    check("basic_not_early", 32'(issue_valid), 0);
    tick();
    check("basic_valid", 32'(issue_valid), 1);
    check("basic_a", issue_a, 5);
    check("basic_b", issue_b, 7);
    check("basic_dest", 32'(issue_dest_tag), 3);
    check("basic_ctrl", 32'(issue_alu_ctrl), 32'b0010);
    check("basic_count_zero", 32'(count), 0);
    tick();
    check("basic_drain", 32'(issue_valid), 0);

    // wakeup
    disp(4'b0011, 6'd4, 0, 6'd9, 32'd0, 1, 0, 32'd1);
    tick(); disp_valid = 1'b0;
    check("wk_count", 32'(count), 1);
    tick();
    check("wk_wait", 32'(issue_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 32'hF0;
    tick(); cdb_valid = 1'b0;
    check("wk_not_before", 32'(issue_valid), 0);
    tick();
    check("wk_valid", 32'(issue_valid), 1);
    check("wk_a", issue_a, 32'hF0);
    check("wk_dest", 32'(issue_dest_tag), 4);
    tick();

    // age order
    for (int i = 1; i <= 4; i++) begin
      disp(4'b0001, 6'(i), 0, 6'd20, 32'd0, 1, 0, 32'(i));
      tick();
    end
    disp_valid = 1'b0;
    check("age_full_count", 32'(count), 4);
    check("age_full_ready", 32'(disp_ready), 0);
    cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_value = 32'h55;
    tick(); cdb_valid = 1'b0;
    check("age_not_before", 32'(issue_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("age_valid", 32'(issue_valid), 1);
      check("age_order", 32'(issue_dest_tag), 32'(i));
      check("age_a", issue_a, 32'h55);
    end
    check("age_count_end", 32'(count), 0);
    tick();
    check("age_drain", 32'(issue_valid), 0);

    // backpressure and full
    issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(4'b0110, 6'(10 + i), 1, 0, 32'h100 + 32'(i), 1, 0, 32'h200 + 32'(i));
      if (i == 5) check("bp_ready_low_before_6th", 32'(disp_ready), 0);
      tick();
    end
    disp_valid = 1'b0;
    check("bp_count", 32'(count), 4);
    check("bp_disp_ready", 32'(disp_ready), 0);
    check("bp_valid", 32'(issue_valid), 1);
    check("bp_dest", 32'(issue_dest_tag), 10);
    tick();
    check("bp_hold_dest", 32'(issue_dest_tag), 10);
    check("bp_hold_a", issue_a, 32'h100);
    check("bp_hold_b", issue_b, 32'h200);
    issue_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      tick();
      check("bp_drain_dest", 32'(issue_dest_tag), 32'(i));
      check("bp_drain_count", 32'(count), 32'(14 - i));
    end
    tick();
    check("bp_6th_dropped", 32'(issue_valid), 0);

    // same-cycle bypass
    disp(4'b0110, 6'd7, 1, 0, 32'h10, 0, 6'd12, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_value = 32'h1234;
    tick(); disp_valid = 1'b0; cdb_valid = 1'b0;
    check("byp_count", 32'(count), 1);
    tick();
    check("byp_valid", 32'(issue_valid), 1);
    check("byp_b", issue_b, 32'h1234);
    check("byp_dest", 32'(issue_dest_tag), 7);
    tick();

    // flush vs dispatch, with the 1111 code carried like any other
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'b1111, 6'(30 + i), 1, 0, 32'(i), 1, 0, 32'(i));
      tick();
    end
    check("fl_pre_count", 32'(count), 3);
    check("fl_pre_valid", 32'(issue_valid), 1);
    check("fl_ctrl_1111", 32'(issue_alu_ctrl), 32'hF);
    disp(4'b0010, 6'd40, 1, 0, 32'd1, 1, 0, 32'd2);
    flush = 1'b1;
    tick(); flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b1;
    check("fl_count", 32'(count), 0);
    check("fl_valid", 32'(issue_valid), 0);
    check("fl_disp_ready", 32'(disp_ready), 1);
    tick();
    check("fl_disp_discarded", 32'(issue_valid), 0);
    check("fl_count_stays", 32'(count), 0);

    // asynchronous reset mid-operation
    disp(4'b0010, 6'd5, 0, 6'd22, 32'd0, 1, 0, 32'd3);
    tick(); disp_valid = 1'b0;
    check("ar_count_pre", 32'(count), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_valid", 32'(issue_valid), 0);
    tick(); rst = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd22; cdb_value = 32'h9;
    tick(); cdb_valid = 1'b0;
    tick();
    check("ar_nothing_survives", 32'(issue_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
